gpio_ctrl: RTL and testbench
============================

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter: GPIO_W, 16, number of GPIO pins (width of all gpio_* and bus data ports).
REQ-002 SHALL have port: clk  input  1  master clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: bus_req  input  1  register access request, held until bus_ack.
REQ-005 SHALL have port: bus_we  input  1  1 = write, 0 = read; sampled with bus_req.
REQ-006 SHALL have port: bus_addr  input  3  register index.
REQ-007 SHALL have port: bus_wdata  input  GPIO_W  write data.
REQ-008 SHALL have port: bus_rdata  output  GPIO_W  read data; valid only while bus_ack=1, else 0.
REQ-009 SHALL have port: bus_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: gpio_dr  output  GPIO_W  output data register driving the pad mux.
REQ-011 SHALL have port: gpio_ts  output  GPIO_W  per-pin drive enable (1 = drive gpio_dr, 0 = hi-Z).
REQ-012 SHALL have port: gpio_ps  input  GPIO_W  asynchronous pin state returned from the pads.
REQ-013 SHALL have port: irq  output  1  level interrupt, OR of enabled pending bits.

Function
REQ-014 Register map SHALL be: 0 DATA rw; 1 TS rw; 2 IN ro (synchronized pins); 3 IRQ_EN rw; 4 IRQ_POL rw (1 = rising edge, 0 = falling edge); 5 IRQ_PEND rw1c; 6 SET wo (DATA |= wdata); 7 CLR wo (DATA &= ~wdata).
REQ-015 Handshake: request accepted on a rising edge with bus_req=1 and bus_ack=0; bus_ack=1 the following cycle for exactly one cycle; back-to-back accesses take 2 cycles each.
REQ-016 Writes SHALL take effect on the same edge that raises bus_ack; gpio_dr/gpio_ts update together with bus_ack.
REQ-017 Reads of SET, CLR, or writes to IN SHALL return 0 / be ignored, and still ack.
REQ-018 gpio_ps SHALL pass a 2-flop synchronizer; IN reflects a pin change 2 edges after it settles.
REQ-019 Edge detect SHALL compare the synchronized value against its 1-cycle-delayed copy; a qualifying edge per IRQ_POL sets the IRQ_PEND bit on the 3rd edge after the pin change, regardless of IRQ_EN.
REQ-020 irq SHALL be registered-free combinational: |(IRQ_PEND & IRQ_EN).
REQ-021 Simultaneous edge detection and W1C of the same bit SHALL leave the bit set (set wins).
REQ-022 Writing IRQ_POL SHALL NOT itself generate a pending bit.

Reset
REQ-023 On reset=1: DATA, TS, IRQ_EN, IRQ_PEND = 0; IRQ_POL = all 1s; synchronizer/edge flops = 0; bus_ack = 0; bus_rdata = 0; irq = 0; all pins hi-Z.
REQ-024 Reset asserted mid-transaction SHALL abort it with no ack; the requester re-issues after release.
REQ-025 First edge after release SHALL NOT produce a spurious pending bit from a pin already high (edge flops load from synchronizer, not from 0, for 2 cycles after release).

Configuration
REQ-026 Macro GPIO_IRQ_EN defined: interrupt logic (REQ-019..022, registers 3-5) present.
REQ-027 Macro GPIO_IRQ_EN undefined: registers 3-5 read 0 and ignore writes; irq tied 0; edge-detect flops removed; synchronizer and IN retained.

Structure
REQ-028 Package gpio_pkg SHALL hold GPIO_W default, register address constants (ADDR_DATA..ADDR_CLR) and the IRQ_POL reset value.
REQ-029 Sub-module gpio_sync SHALL implement the synchronizer plus delayed copy and rise/fall vectors; gpio_ctrl holds the register bank and handshake.

Verification
REQ-030 Write DATA=0xA5A5, TS=0x00FF -> gpio_dr=0xA5A5, gpio_ts=0x00FF on ack edge; read back equal.
REQ-031 DATA=0x00F0; write SET=0x000F then CLR=0x0030 -> DATA reads 0x00CF.
REQ-032 IRQ_EN=0x0001, IRQ_POL=1, pin0 0->1 -> IRQ_PEND=0x0001 after 3 edges, irq=1; write PEND=0x0001 -> irq=0.
REQ-033 IRQ_POL bit2=0, pin2 1->0 with IRQ_EN=0 -> PEND bit2 set, irq stays 0; set IRQ_EN bit2 -> irq=1.
REQ-034 Pin edge coincident with W1C of same bit -> PEND bit remains 1.
REQ-035 Assert reset during pending read -> no ack, all outputs at REQ-023 values; rebuild without GPIO_IRQ_EN -> reg 5 reads 0, irq never 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: default width, register map, IRQ_POL reset value.
package gpio_pkg;

    localparam int unsigned GPIO_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_TS       = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_POL  = 3'd4;
    localparam logic [2:0] ADDR_IRQ_PEND = 3'd5;
    localparam logic [2:0] ADDR_SET      = 3'd6;
    localparam logic [2:0] ADDR_CLR      = 3'd7;

    // Replicated across all pins: every pin defaults to rising-edge sensitivity.
    localparam logic IRQ_POL_RST_BIT = 1'b1;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pin synchronizer; with GPIO_IRQ_EN also a delayed copy and rise/fall edge vectors.
module gpio_sync #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] ps,
    output logic [W-1:0] sync
`ifdef GPIO_IRQ_EN
    ,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
`endif
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ps;
            sync_q <= meta_q;
        end
    end

    assign sync = sync_q;

`ifdef GPIO_IRQ_EN
    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;
    logic [1:0]   warm_q;
    logic [1:0]   warm_d;
    logic         armed;

    // Until the synchronizer holds real pin data, the delayed copy tracks the first stage
    // so a pin that is already high at release is not seen as an edge.
    assign armed = (warm_q == 2'd2);

    always_comb begin
        warm_d = armed ? warm_q : warm_q + 2'd1;
        dly_d  = armed ? sync_q : meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q <= 2'd0;
            dly_q  <= '0;
        end else begin
            warm_q <= warm_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = armed ? (sync_q & ~dly_q) : '0;
    assign fall = armed ? (~sync_q & dly_q) : '0;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO register bank and req/ack bus handshake. Define GPIO_IRQ_EN to include the
// edge-interrupt registers (IRQ_EN, IRQ_POL, IRQ_PEND) and the irq output.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_W = GPIO_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [2:0]        bus_addr,
    input  logic [GPIO_W-1:0] bus_wdata,
    output logic [GPIO_W-1:0] bus_rdata,
    output logic              bus_ack,
    output logic [GPIO_W-1:0] gpio_dr,
    output logic [GPIO_W-1:0] gpio_ts,
    input  logic [GPIO_W-1:0] gpio_ps,
    output logic              irq
);

    logic              ack_q;
    logic              accept;
    logic              wr;
    logic [GPIO_W-1:0] rdata_q;
    logic [GPIO_W-1:0] rdata_d;
    logic [GPIO_W-1:0] rd_val;
    logic [GPIO_W-1:0] data_q;
    logic [GPIO_W-1:0] data_d;
    logic [GPIO_W-1:0] ts_q;
    logic [GPIO_W-1:0] ts_d;
    logic [GPIO_W-1:0] pin_sync;

    // A held request is not re-accepted during its own ack cycle.
    assign accept = bus_req & ~ack_q;
    assign wr     = accept & bus_we;

`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] pin_rise;
    logic [GPIO_W-1:0] pin_fall;
    logic [GPIO_W-1:0] en_q;
    logic [GPIO_W-1:0] en_d;
    logic [GPIO_W-1:0] pol_q;
    logic [GPIO_W-1:0] pol_d;
    logic [GPIO_W-1:0] pend_q;
    logic [GPIO_W-1:0] pend_d;
    logic [GPIO_W-1:0] hits;
`endif

    gpio_sync #(
        .W(GPIO_W)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .ps   (gpio_ps),
        .sync (pin_sync)
`ifdef GPIO_IRQ_EN
        ,
        .rise (pin_rise),
        .fall (pin_fall)
`endif
    );

    always_comb begin
        data_d = data_q;
        ts_d   = ts_q;
        if (wr) begin
            case (bus_addr)
                ADDR_DATA: data_d = bus_wdata;
                ADDR_TS:   ts_d   = bus_wdata;
                ADDR_SET:  data_d = data_q | bus_wdata;
                ADDR_CLR:  data_d = data_q & ~bus_wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            ADDR_DATA:     rd_val = data_q;
            ADDR_TS:       rd_val = ts_q;
            ADDR_IN:       rd_val = pin_sync;
`ifdef GPIO_IRQ_EN
            ADDR_IRQ_EN:   rd_val = en_q;
            ADDR_IRQ_POL:  rd_val = pol_q;
            ADDR_IRQ_PEND: rd_val = pend_q;
`endif
            default:       rd_val = '0;
        endcase
        rdata_d = (accept && !bus_we) ? rd_val : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            data_q  <= '0;
            ts_q    <= '0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rdata_d;
            data_q  <= data_d;
            ts_q    <= ts_d;
        end
    end

`ifdef GPIO_IRQ_EN
    always_comb begin
        en_d   = en_q;
        pol_d  = pol_q;
        pend_d = pend_q;
        hits   = (pin_rise & pol_q) | (pin_fall & ~pol_q);
        if (wr) begin
            case (bus_addr)
                ADDR_IRQ_EN:   en_d   = bus_wdata;
                ADDR_IRQ_POL:  pol_d  = bus_wdata;
                ADDR_IRQ_PEND: pend_d = pend_q & ~bus_wdata;
                default:       ;
            endcase
        end
        // A new edge on the same edge as its W1C keeps the bit set.
        pend_d = pend_d | hits;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q   <= '0;
            pol_q  <= {GPIO_W{IRQ_POL_RST_BIT}};
            pend_q <= '0;
        end else begin
            en_q   <= en_d;
            pol_q  <= pol_d;
            pend_q <= pend_d;
        end
    end

    assign irq = |(pend_q & en_q);
`else
    assign irq = 1'b0;
`endif

    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;
    assign gpio_dr   = data_q;
    assign gpio_ts   = ts_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed steps plus random traffic against a pin-history model.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic [15:0] gpio_dr;
    logic [15:0] gpio_ts;
    logic [15:0] gpio_ps;
    logic        irq;

    gpio_ctrl #(
        .GPIO_W(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .gpio_dr  (gpio_dr),
        .gpio_ts  (gpio_ts),
        .gpio_ps  (gpio_ps),
        .irq      (irq)
    );

    always #5 clk = ~clk;

`ifdef GPIO_IRQ_EN
    localparam bit HasIrq = 1'b1;
`else
    localparam bit HasIrq = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register values plus the pin value seen before every edge since release.
    logic [15:0] m_data, m_ts, m_en, m_pol, m_pend;
    logic        m_ack;
    logic [15:0] hist[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_data = '0;
        m_ts   = '0;
        m_en   = '0;
        m_pol  = '1;
        m_pend = '0;
        m_ack  = 1'b0;
        hist.delete();
    endtask

    function automatic logic [15:0] model_in();
        int k = hist.size();
        // A pin level needs two edges to reach IN.
        return (k >= 2) ? hist[k-2] : 16'h0000;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_data;
            3'd1: return m_ts;
            3'd2: return model_in();
            3'd3: return HasIrq ? m_en : 16'h0000;
            3'd4: return HasIrq ? m_pol : 16'h0000;
            3'd5: return HasIrq ? m_pend : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // One clock edge: predict its effect, let it happen, then compare every output.
    task automatic tick();
        logic        acc;
        logic [15:0] exp_rdata, hits, now_v, prev_v;
        int          k;
        acc       = bus_req && !m_ack;
        exp_rdata = (acc && !bus_we) ? model_read(bus_addr) : 16'h0000;
        hist.push_back(gpio_ps);
        k    = hist.size();
        hits = '0;
        // A pin change is flagged on the third edge after it; the first three edges after
        // release never flag anything.
        if (HasIrq && k >= 4) begin
            now_v  = hist[k-3];
            prev_v = hist[k-4];
            hits   = (now_v & ~prev_v & m_pol) | (~now_v & prev_v & ~m_pol);
        end
        if (acc && bus_we) begin
            case (bus_addr)
                3'd0: m_data = bus_wdata;
                3'd1: m_ts   = bus_wdata;
                3'd3: if (HasIrq) m_en = bus_wdata;
                3'd4: if (HasIrq) m_pol = bus_wdata;
                3'd5: if (HasIrq) m_pend = m_pend & ~bus_wdata;
                3'd6: m_data = m_data | bus_wdata;
                3'd7: m_data = m_data & ~bus_wdata;
                default: ;
            endcase
        end
        m_pend = m_pend | hits;
        m_ack  = acc;
        @(posedge clk);
        #1;
        chk("ack", {15'h0, bus_ack}, {15'h0, m_ack});
        chk("rdata", bus_rdata, exp_rdata);
        chk("gpio_dr", gpio_dr, m_data);
        chk("gpio_ts", gpio_ts, m_ts);
        chk("irq", {15'h0, irq}, {15'h0, |(m_pend & m_en)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_req = 1'b0;
        bus_we  = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        tick();
        d       = bus_rdata;
        bus_req = 1'b0;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, {15'h0, bus_ack}, 16'h0000);
        chk({tag, "_rdata"}, bus_rdata, 16'h0000);
        chk({tag, "_dr"}, gpio_dr, 16'h0000);
        chk({tag, "_ts"}, gpio_ts, 16'h0000);
        chk({tag, "_irq"}, {15'h0, irq}, 16'h0000);
    endtask

    logic [15:0] rv;

    initial begin
        reset     = 1'b1;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        gpio_ps   = 16'hFFFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Pins already high at release: no pending bits.
        idle(6);
        bus_read(3'd5, rv);
        chk("pend_after_release", rv, 16'h0000);
        bus_read(3'd2, rv);
        chk("in_after_release", rv, 16'hFFFF);
        bus_read(3'd4, rv);
        chk("pol_reset", rv, HasIrq ? 16'hFFFF : 16'h0000);

        // DATA / TS write and read back.
        bus_write(3'd0, 16'hA5A5);
        bus_write(3'd1, 16'h00FF);
        chk("dr_a5a5", gpio_dr, 16'hA5A5);
        chk("ts_00ff", gpio_ts, 16'h00FF);
        bus_read(3'd0, rv);
        chk("rd_data", rv, 16'hA5A5);
        bus_read(3'd1, rv);
        chk("rd_ts", rv, 16'h00FF);

        // SET / CLR, plus write-only and read-only holes.
        bus_write(3'd0, 16'h00F0);
        bus_write(3'd6, 16'h000F);
        bus_write(3'd7, 16'h0030);
        bus_read(3'd0, rv);
        chk("set_clr", rv, 16'h00CF);
        bus_read(3'd6, rv);
        chk("rd_set_zero", rv, 16'h0000);
        bus_read(3'd7, rv);
        chk("rd_clr_zero", rv, 16'h0000);
        bus_write(3'd2, 16'h1234);
        bus_read(3'd0, rv);
        chk("in_write_ignored", rv, 16'h00CF);

        // Rising edge on pin0 with interrupt enabled.
        gpio_ps = 16'h0000;
        idle(5);
        bus_write(3'd5, 16'hFFFF);
        bus_write(3'd3, 16'h0001);
        gpio_ps = 16'h0001;
        idle(2);
        chk("irq_before_3rd", {15'h0, irq}, 16'h0000);
        idle(1);
        chk("irq_on_3rd", {15'h0, irq}, {15'h0, HasIrq});
        bus_read(3'd5, rv);
        chk("pend_pin0", rv, HasIrq ? 16'h0001 : 16'h0000);
        bus_write(3'd5, 16'h0001);
        chk("irq_cleared", {15'h0, irq}, 16'h0000);

        // Falling edge on pin2 with it disabled, then enable it.
        bus_write(3'd4, 16'hFFFB);
        gpio_ps = 16'h0005;
        idle(4);
        bus_write(3'd5, 16'hFFFF);
        gpio_ps = 16'h0001;
        idle(4);
        bus_read(3'd5, rv);
        chk("pend_pin2_fall", rv, HasIrq ? 16'h0004 : 16'h0000);
        chk("irq_masked", {15'h0, irq}, 16'h0000);
        bus_write(3'd3, 16'h0004);
        chk("irq_enabled", {15'h0, irq}, {15'h0, HasIrq});

        // Edge lands on the same edge as its W1C: set wins.
        bus_write(3'd3, 16'h0000);
        bus_write(3'd5, 16'hFFFF);
        gpio_ps = 16'h0003;
        idle(2);
        bus_write(3'd5, 16'h0002);
        bus_read(3'd5, rv);
        chk("set_wins", rv, HasIrq ? 16'h0002 : 16'h0000);

        // Changing polarity alone creates no pending bit.
        bus_write(3'd4, 16'h0000);
        idle(3);
        bus_read(3'd5, rv);
        chk("pol_write_no_pend", rv, HasIrq ? 16'h0002 : 16'h0000);

        // Random traffic and pin activity.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_ps = 16'($urandom);
            case ($urandom_range(0, 2))
                0: bus_write(3'($urandom_range(0, 7)), 16'($urandom));
                1: bus_read(3'($urandom_range(0, 7)), rv);
                default: tick();
            endcase
        end

        // Reset during a pending read: no ack, then re-issued after release.
        bus_write(3'd0, 16'h5A5A);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 3'd0;
        #1;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("midreset_held");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        chk("reissue_ack", {15'h0, bus_ack}, 16'h0001);
        chk("reissue_data", bus_rdata, 16'h0000);
        bus_req = 1'b0;
        tick();
        bus_read(3'd3, rv);
        chk("en_after_reset", rv, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
